// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if
// Groups the signals of the fetch stage that cross its boundary: the redirect
// from the branch controller, the instruction-memory request/response
// channels, and the valid/ready channel toward decode.
//   master : the fetch unit (drives fetch requests and the decode channel)
//   slave  : the surroundings (branch controller, memory, decode)
// Clock and reset are plain ports on the fetch unit itself.
interface pc_fetch_unit_if;
    logic        pc_sel;          // redirect request
    logic [31:0] target_pc;       // redirect target, [1:0] ignored
    logic        imem_req_valid;  // fetch request valid
    logic        imem_req_ready;  // memory accepts request
    logic [31:0] imem_addr;       // word-aligned fetch address
    logic        imem_rsp_valid;  // in-order response valid
    logic [31:0] imem_rsp_data;   // instruction word
    logic        if_valid;        // buffer head valid toward decode
    logic        if_ready;        // decode accepts head
    logic [31:0] if_instr;        // head instruction
    logic [31:0] if_pc;           // head PC

    modport master (
        input  pc_sel, target_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        output imem_req_valid, imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output pc_sel, target_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Instruction-fetch stage. Owns the program counter, issues in-order word
// fetches, buffers returned instructions together with their PCs in a small
// FIFO and presents the head to decode. A redirect (pc_sel) flushes the
// buffer, marks every in-flight response for discard and restarts fetching
// at the target.
// Ports:
//   clk     : clock, all state changes on its rising edge
//   reset_n : synchronous active-low reset
//   bus     : pc_fetch_unit_if.master (redirect, imem req/rsp, decode channel)
// Parameters:
//   RESET_PC : first PC fetched after reset
//   DEPTH    : buffer entries = credit limit on outstanding + buffered fetches
//              (power of two, >= 2)
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    pc_fetch_unit_if.master  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_reg;     // next address to request
    logic [31:0]   rsp_pc_reg;       // PC tagged onto the next kept response
    logic [CW-1:0] outstanding_reg;  // accepted, not yet answered
    logic [CW-1:0] drop_cnt_reg;     // in-flight responses still to discard
    logic [CW-1:0] count_reg;        // buffered entries
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic [CW:0] credit_used;
    logic        req_fire;
    logic        push;
    logic        pop;
    logic        head_valid;
    logic        unused_target_bits;

    assign unused_target_bits = ^bus.target_pc[1:0];

    // Discarded responses still hold a credit through outstanding_reg, so the
    // sum below bounds buffer occupancy even while a drop is pending.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, count_reg};

    // Gated by reset_n so no request escapes during the reset cycle itself.
    assign bus.imem_req_valid = reset_n && !bus.pc_sel && (credit_used < DEPTH_C);
    assign bus.imem_addr      = fetch_pc_reg;

    assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
    assign head_valid = (count_reg != '0);
    // A redirect voids any push or pop in its own cycle.
    assign push       = bus.imem_rsp_valid && (drop_cnt_reg == '0) && !bus.pc_sel;
    assign pop        = head_valid && bus.if_ready && !bus.pc_sel;

    // Head shows zeros when empty so stale storage never leaks onto if_*.
    assign bus.if_valid = head_valid;
    assign bus.if_pc    = head_valid ? pc_mem[rd_ptr_reg]    : 32'h0;
    assign bus.if_instr = head_valid ? instr_mem[rd_ptr_reg] : 32'h0;

    // Buffer storage needs no reset: entries are only visible through count_reg.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            pc_mem[wr_ptr_reg]    <= rsp_pc_reg;
            instr_mem[wr_ptr_reg] <= bus.imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else if (bus.pc_sel) begin
            fetch_pc_reg    <= {bus.target_pc[31:2], 2'b00};
            rsp_pc_reg      <= {bus.target_pc[31:2], 2'b00};
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            // Everything still in flight after this cycle belongs to the old
            // stream; a response landing now is already gone.
            outstanding_reg <= outstanding_reg - CW'(bus.imem_rsp_valid);
            drop_cnt_reg    <= outstanding_reg - CW'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end
            outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(bus.imem_rsp_valid);
            if (bus.imem_rsp_valid && (drop_cnt_reg != '0)) begin
                drop_cnt_reg <= drop_cnt_reg - CW'(1);
            end
            if (push) begin
                rsp_pc_reg <= rsp_pc_reg + 32'd4;
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// Drives pc_fetch_unit with an in-order instruction memory model of
// configurable latency and checks the decode stream against a reference PC
// model plus hand-computed directed expectations.
module tb_pc_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk;
    logic reset_n;
    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        int          lat;       // memory latency for this vector
        int          pre;       // cycles run after reset before the redirect
        logic [31:0] target;    // redirect target (low bits dirty)
        int          req_wait;  // cycles after R+1 before the target is requested
        logic [31:0] exp_pc;    // first PC delivered after redirect
        logic [31:0] exp_next;  // second PC delivered
    } vec_t;

    mreq_t       mq[$];
    logic [31:0] pop_log[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          n_pop    = 0;
    int          rsp_cnt  = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock cycle: entered and left at the falling edge.
    task automatic step();
        logic req_fire;
        logic pop;
        int   due;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memfn(mq[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        #1;
        req_fire = bus.imem_req_valid && bus.imem_req_ready;
        pop      = bus.if_valid && bus.if_ready;
        if (!reset_n) begin
            mq.delete();
            exp_pc    = RST_PC;
            exp_fetch = RST_PC;
        end else begin
            if (bus.imem_req_valid) check("imem_addr", bus.imem_addr, exp_fetch);
            if (bus.if_valid && !bus.pc_sel) begin
                check("if_pc", bus.if_pc, exp_pc);
                check("if_instr", bus.if_instr, memfn(exp_pc));
            end
            if (bus.imem_rsp_valid) begin
                void'(mq.pop_front());
                rsp_cnt++;
            end
            if (req_fire) begin
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (mq.size() > 0 && due <= mq[mq.size()-1].due) due = mq[mq.size()-1].due + 1;
                mq.push_back('{addr: bus.imem_addr, due: due});
            end
            if (bus.pc_sel) begin
                exp_pc    = bus.target_pc & 32'hFFFF_FFFC;
                exp_fetch = bus.target_pc & 32'hFFFF_FFFC;
            end else begin
                if (req_fire) exp_fetch = exp_fetch + 32'd4;
                if (pop) begin
                    $display("pop pc=%h instr=%h cycle=%0d", bus.if_pc, bus.if_instr, cyc);
                    pop_log.push_back(bus.if_pc);
                    n_pop++;
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        bus.pc_sel = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (!bus.if_valid && k < budget) begin
            step();
            k++;
        end
        check({name, "_valid_timeout"}, 32'(bus.if_valid), 32'd1);
    endtask

    task automatic wait_req(input string name, input int budget, output int waited);
        waited = 0;
        #1;
        while (!bus.imem_req_valid && waited < budget) begin
            step();
            waited++;
            #1;
        end
        check({name, "_req_timeout"}, 32'(bus.imem_req_valid), 32'd1);
    endtask

    vec_t vecs[4];

    initial begin
        int base;
        int waited;
        int k;

        vecs[0] = '{lat: 3, pre: 2, target: 32'h0000_2002, req_wait: 1, exp_pc: 32'h0000_2000, exp_next: 32'h0000_2004};
        vecs[1] = '{lat: 1, pre: 3, target: 32'hFFFF_FFFE, req_wait: 0, exp_pc: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
        vecs[2] = '{lat: 2, pre: 4, target: 32'h0000_0043, req_wait: 0, exp_pc: 32'h0000_0040, exp_next: 32'h0000_0044};
        vecs[3] = '{lat: 4, pre: 1, target: 32'h1234_5679, req_wait: 0, exp_pc: 32'h1234_5678, exp_next: 32'h1234_567C};

        clk                = 1'b0;
        reset_n            = 1'b0;
        bus.pc_sel         = 1'b0;
        bus.target_pc      = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.if_ready       = 1'b1;
        exp_pc             = RST_PC;
        exp_fetch          = RST_PC;
        @(negedge clk);

        // Reset state and sequential fetch
        lat_min = 1; lat_max = 1;
        step();
        #1;
        check("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_imem_addr", bus.imem_addr, RST_PC);
        check("rst_if_pc", bus.if_pc, 32'h0);
        check("rst_if_instr", bus.if_instr, 32'h0);
        reset_n = 1'b1;
        #1;
        check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        pop_log.delete();
        step();
        step();
        check("seq_valid_n2", 32'(bus.if_valid), 32'd1);
        check("seq_first_pc", bus.if_pc, 32'h0000_0100);
        check("seq_first_instr", bus.if_instr, memfn(32'h0000_0100));
        k = 0;
        while (pop_log.size() < 3 && k < 12) begin step(); k++; end
        check("seq_pop_count", 32'(pop_log.size() >= 3), 32'd1);
        if (pop_log.size() >= 3) begin
            check("seq_pc0", pop_log[0], 32'h0000_0100);
            check("seq_pc1", pop_log[1], 32'h0000_0104);
            check("seq_pc2", pop_log[2], 32'h0000_0108);
        end
        $display("sequential fetch done");

        // Table-driven redirects
        for (int v = 0; v < 4; v++) begin
            lat_min = vecs[v].lat; lat_max = vecs[v].lat;
            bus.if_ready = 1'b1;
            do_reset();
            for (int p = 0; p < vecs[v].pre; p++) step();
            bus.pc_sel    = 1'b1;
            bus.target_pc = vecs[v].target;
            #1;
            check("redir_cycle_req_valid", 32'(bus.imem_req_valid), 32'd0);
            step();
            bus.pc_sel = 1'b0;
            check("redir_flush_valid", 32'(bus.if_valid), 32'd0);
            wait_req("redir", 10, waited);
            check("redir_req_wait", 32'(waited), 32'(vecs[v].req_wait));
            check("redir_req_addr", bus.imem_addr, vecs[v].exp_pc);
            wait_valid("redir", 12);
            check("redir_first_pc", bus.if_pc, vecs[v].exp_pc);
            check("redir_first_instr", bus.if_instr, memfn(vecs[v].exp_pc));
            step();
            wait_valid("redir_next", 12);
            check("redir_next_pc", bus.if_pc, vecs[v].exp_next);
            $display("redirect vector %0d target=%h done", v, vecs[v].target);
        end

        // Backpressure
        lat_min = 1; lat_max = 1;
        do_reset();
        bus.if_ready = 1'b0;
        base = rsp_cnt;
        for (int c = 0; c < 10; c++) begin
            check("credit_bound", 32'((mq.size() + (rsp_cnt - base)) <= 2), 32'd1);
            step();
        end
        #1;
        check("bp_req_valid_low", 32'(bus.imem_req_valid), 32'd0);
        check("bp_full_valid", 32'(bus.if_valid), 32'd1);
        check("bp_head_pc", bus.if_pc, 32'h0000_0100);
        bus.if_ready = 1'b1;
        pop_log.delete();
        step();
        check("bp_after_pop_pc", bus.if_pc, 32'h0000_0104);
        for (int c = 0; c < 8; c++) step();
        check("bp_pops", 32'(pop_log.size() >= 4), 32'd1);
        if (pop_log.size() >= 4) begin
            check("bp_pc0", pop_log[0], 32'h0000_0100);
            check("bp_pc1", pop_log[1], 32'h0000_0104);
            check("bp_pc2", pop_log[2], 32'h0000_0108);
            check("bp_pc3", pop_log[3], 32'h0000_010C);
        end
        $display("backpressure done");

        // Redirect at full with pop, then redirects coincident with responses
        lat_min = 2; lat_max = 2;
        do_reset();
        bus.if_ready = 1'b0;
        for (int c = 0; c < 5; c++) step();
        check("edge_full_valid", 32'(bus.if_valid), 32'd1);
        bus.if_ready  = 1'b1;
        bus.pc_sel    = 1'b1;
        bus.target_pc = 32'h0000_0040;
        step();
        bus.pc_sel = 1'b0;
        check("edge_flush_valid", 32'(bus.if_valid), 32'd0);
        step();
        step();
        bus.pc_sel    = 1'b1;
        bus.target_pc = 32'h0000_0080;
        step();
        step();
        bus.pc_sel = 1'b0;
        pop_log.delete();
        wait_valid("edge", 12);
        check("edge_first_pc", bus.if_pc, 32'h0000_0080);
        check("edge_first_instr", bus.if_instr, memfn(32'h0000_0080));
        for (int c = 0; c < 8; c++) step();
        check("edge_pops", 32'(pop_log.size() >= 2), 32'd1);
        if (pop_log.size() >= 2) begin
            check("edge_pc0", pop_log[0], 32'h0000_0080);
            check("edge_pc1", pop_log[1], 32'h0000_0084);
        end
        $display("redirect edge cases done");

        // Reset mid-operation with a full buffer
        lat_min = 1; lat_max = 1;
        do_reset();
        bus.if_ready = 1'b0;
        for (int c = 0; c < 5; c++) step();
        check("mid_full_valid", 32'(bus.if_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        step();
        reset_n = 1'b1;
        #1;
        check("mid_if_valid", 32'(bus.if_valid), 32'd0);
        check("mid_imem_addr", bus.imem_addr, RST_PC);
        check("mid_if_pc", bus.if_pc, 32'h0);
        check("mid_req_valid", 32'(bus.imem_req_valid), 32'd1);
        bus.if_ready = 1'b1;
        wait_valid("mid", 8);
        check("mid_first_pc", bus.if_pc, RST_PC);
        $display("mid-operation reset done");

        // Random stress
        lat_min = 1; lat_max = 4;
        do_reset();
        base = n_pop;
        for (int c = 0; c < 1500; c++) begin
            bus.imem_req_ready = ($urandom_range(3, 0) != 0);
            bus.if_ready       = ($urandom_range(3, 0) != 0);
            bus.pc_sel         = ($urandom_range(29, 0) == 0);
            bus.target_pc      = $urandom();
            step();
        end
        bus.pc_sel = 1'b0;
        check("stress_progress", 32'((n_pop - base) > 20), 32'd1);
        $display("random stress done, %0d pops", n_pop - base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
